prog_loader: RTL and testbench

Serial program loader that writes the 16-bit instruction/data memory which the multicycle CPU later reads. It receives a framed byte stream on a UART line, assembles big-endian 16-bit words, and drives a write-only memory port from address 0 upward. While loading, it holds the CPU, and it releases the CPU once a valid frame has completed. It sits beside the memory in the top level and owns the memory write port whenever `cpu_hold` is high.

---
 rtl/loader_pkg.sv | 14 +
 rtl/uart_rx_byte.sv | 85 ++++++++
 rtl/prog_loader.sv | 157 +++++++++++++++
 tb/tb_prog_loader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// loader_pkg: header constant, parser/receiver state encodings and baud divisor helper
package loader_pkg;

    localparam logic [7:0] HDR = 8'hA5;

    typedef enum logic [2:0] {IDLE, COUNT, DATA_HI, DATA_LO, CHECK, DONE} state_t;

    typedef enum logic [1:0] {RX_WAIT, RX_START, RX_DATA, RX_STOP} rx_state_t;

    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver with 2-flop synchronizer, start-bit glitch reject and stop-bit check
module uart_rx_byte
    import loader_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int DIV = calc_div(CLK_HZ, BAUD);
    localparam logic [15:0] FULL = 16'(DIV - 1);
    localparam logic [15:0] HALF = 16'(DIV / 2 - 1);

    rx_state_t   rs, rs_d;
    logic [2:0]  sync;
    logic [15:0] cnt, cnt_d;
    logic [2:0]  idx, idx_d;
    logic [7:0]  sh_d;
    logic        bv_d, fe_d;
    logic        fall;

    // sync[1] is the synchronized line, sync[2] its previous value for edge detection
    assign fall = sync[2] & ~sync[1];

    // synchronizer and receiver state registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync       <= 3'b111;
            rs         <= RX_WAIT;
            cnt        <= '0;
            idx        <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync       <= {sync[1:0], rx};
            rs         <= rs_d;
            cnt        <= cnt_d;
            idx        <= idx_d;
            byte_data  <= sh_d;
            byte_valid <= bv_d;
            frame_err  <= fe_d;
        end
    end

    // bit timing: half period to mid start bit, full periods for data and stop bits
    always_comb begin
        rs_d  = rs;
        cnt_d = cnt + 16'd1;
        idx_d = idx;
        sh_d  = byte_data;
        bv_d  = 1'b0;
        fe_d  = 1'b0;
        case (rs)
            RX_WAIT: begin
                cnt_d = '0;
                if (fall) rs_d = RX_START;
            end
            RX_START: if (cnt == HALF) begin
                cnt_d = '0;
                idx_d = '0;
                rs_d  = sync[1] ? RX_WAIT : RX_DATA;
            end
            RX_DATA: if (cnt == FULL) begin
                cnt_d = '0;
                sh_d  = {sync[1], byte_data[7:1]};
                idx_d = idx + 3'd1;
                if (idx == 3'd7) rs_d = RX_STOP;
            end
            RX_STOP: if (cnt == FULL) begin
                bv_d = sync[1];
                fe_d = ~sync[1];
                rs_d = RX_WAIT;
            end
            default: rs_d = RX_WAIT;
        endcase
    end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: UART framed program loader writing 16-bit words; optional checksum via LOADER_CHECKSUM_EN
module prog_loader
    import loader_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam int CW   = ADDR_W + 1;
    localparam int MAXW = 1 << ADDR_W;

    logic              byte_valid, frame_err;
    logic [7:0]        byte_data;
    state_t            st, st_d;
    logic [CW-1:0]     wcnt, wcnt_d, n, n_d;
    logic [7:0]        hi, hi_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;
    logic              we_d, hold_d, done_d, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        xacc, xacc_d;
`endif

    uart_rx_byte #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
        .clock     (clock),
        .reset     (reset),
        .rx        (rx),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    // parser state and registered memory-port / status outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st        <= IDLE;
            wcnt      <= '0;
            n         <= '0;
            hi        <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            xacc      <= '0;
`endif
        end else begin
            st        <= st_d;
            wcnt      <= wcnt_d;
            n         <= n_d;
            hi        <= hi_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            mem_we    <= we_d;
            cpu_hold  <= hold_d;
            done      <= done_d;
            error     <= err_d;
`ifdef LOADER_CHECKSUM_EN
            xacc      <= xacc_d;
`endif
        end
    end

    // frame parser: header, count, word pairs, optional checksum; framing faults abort to IDLE
    always_comb begin
        st_d    = st;
        wcnt_d  = wcnt;
        n_d     = n;
        hi_d    = hi;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        we_d    = 1'b0;
        hold_d  = cpu_hold;
        done_d  = done;
        err_d   = error;
`ifdef LOADER_CHECKSUM_EN
        xacc_d  = xacc;
`endif
        if (frame_err) begin
            err_d = 1'b1;
            st_d  = IDLE;
        end else begin
            case (st)
                IDLE, DONE: if (byte_valid && byte_data == HDR) begin
                    hold_d = 1'b1;
                    done_d = 1'b0;
                    err_d  = 1'b0;
                    wcnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
                    xacc_d = '0;
`endif
                    st_d   = COUNT;
                end
                COUNT: if (byte_valid) begin
                    if (byte_data == 8'd0 || int'(byte_data) > MAXW) begin
                        err_d = 1'b1;
                        st_d  = IDLE;
                    end else begin
                        n_d  = CW'(byte_data);
                        st_d = DATA_HI;
                    end
                end
                DATA_HI: if (byte_valid) begin
                    hi_d   = byte_data;
`ifdef LOADER_CHECKSUM_EN
                    xacc_d = xacc ^ byte_data;
`endif
                    st_d   = DATA_LO;
                end
                DATA_LO: if (byte_valid) begin
                    wdata_d = DATA_W'({hi, byte_data});
                    addr_d  = wcnt[ADDR_W-1:0];
                    we_d    = 1'b1;
                    wcnt_d  = wcnt + CW'(1);
`ifdef LOADER_CHECKSUM_EN
                    xacc_d  = xacc ^ byte_data;
`endif
                    st_d    = (wcnt_d == n) ? CHECK : DATA_HI;
                end
                CHECK: begin
`ifdef LOADER_CHECKSUM_EN
                    if (byte_valid) begin
                        if (byte_data == xacc) begin
                            done_d = 1'b1;
                            hold_d = 1'b0;
                            st_d   = DONE;
                        end else begin
                            err_d = 1'b1;
                            st_d  = IDLE;
                        end
                    end
`else
                    done_d = 1'b1;
                    hold_d = 1'b0;
                    st_d   = DONE;
`endif
                end
                default: st_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed frames over a fast UART line with a write-capture model
module tb_prog_loader;

    localparam int CLK_HZ = 800;
    localparam int BAUD   = 100;
    localparam int DIV    = CLK_HZ / BAUD;
    localparam int ADDR_W = 6;

    typedef logic [7:0] bq_t[$];

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              rx    = 1'b1;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_we, cpu_hold, done, error;

    logic [15:0] tmem [64];
    int          wr_cnt  = 0;
    int          we_long = 0;
    logic        we_prev = 1'b0;
    int          nchk    = 0;
    int          nerr    = 0;

    prog_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(ADDR_W), .DATA_W(16)) dut (
        .clock    (clock),
        .reset    (reset),
        .rx       (rx),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clock = ~clock;

    // capture every write strobe into a shadow memory
    always @(negedge clock) begin
        if (mem_we) begin
            tmem[mem_addr] = mem_wdata;
            wr_cnt++;
        end
        if (mem_we && we_prev) we_long++;
        we_prev = mem_we;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_raw(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (DIV) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clock);
        end
        rx = stop;
        repeat (DIV) @(negedge clock);
        rx = 1'b1;
    endtask

    task automatic send_list(input bq_t q);
        foreach (q[i]) send_raw(q[i], 1'b1);
    endtask

    task automatic idle(input int bits);
        rx = 1'b1;
        repeat (bits * DIV) @(negedge clock);
    endtask

    task automatic send_full(input int words);
        bq_t q;
        q = {8'hA5, 8'h40};
        for (int i = 0; i < words; i++) begin
            q.push_back(8'(i));
            q.push_back(~8'(i));
        end
        send_list(q);
    endtask

    initial begin
        bq_t q;
        int  base;
        int  bad;
        logic [7:0] iv;
        // reset state
        repeat (3) @(negedge clock);
        check("rst_hold", cpu_hold, 1);
        check("rst_done", done, 0);
        check("rst_err", error, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        reset = 1'b0;
        idle(2);

        // good two-word frame
        send_list({8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD});
        idle(1);
`ifdef LOADER_CHECKSUM_EN
        check("pre_cs_done", done, 0);
        check("pre_cs_hold", cpu_hold, 1);
        send_list({8'h40});
        idle(1);
`endif
        check("a_w0", tmem[0], 16'h1234);
        check("a_w1", tmem[1], 16'hABCD);
        check("a_cnt", wr_cnt, 2);
        check("a_addr_hold", mem_addr, 1);
        check("a_wdata_hold", mem_wdata, 16'hABCD);
        check("a_done", done, 1);
        check("a_hold", cpu_hold, 0);
        check("a_err", error, 0);

`ifdef LOADER_CHECKSUM_EN
        // same frame with wrong checksum
        send_list({8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41});
        idle(2);
        check("b_cnt", wr_cnt, 4);
        check("b_err", error, 1);
        check("b_done", done, 0);
        check("b_hold", cpu_hold, 1);
`endif
        // recovery frame
        base = wr_cnt;
        q = {8'hA5, 8'h01, 8'h55, 8'hAA};
`ifdef LOADER_CHECKSUM_EN
        q.push_back(8'hFF);
`endif
        send_list(q);
        idle(2);
        check("c_w0", tmem[0], 16'h55AA);
        check("c_cnt", wr_cnt - base, 1);
        check("c_err", error, 0);
        check("c_done", done, 1);
        check("c_hold", cpu_hold, 0);

        // garbage bytes and a short low glitch while loaded
        base = wr_cnt;
        send_list({8'h00, 8'hFF, 8'h5A});
        idle(1);
        rx = 1'b0;
        repeat (2) @(negedge clock);
        idle(3);
        check("g_cnt", wr_cnt - base, 0);
        check("g_err", error, 0);
        check("g_done", done, 1);
        check("g_hold", cpu_hold, 0);
        q = {8'hA5, 8'h01, 8'h0F, 8'hF0};
`ifdef LOADER_CHECKSUM_EN
        q.push_back(8'hFF);
`endif
        send_list(q);
        idle(2);
        check("g_w0", tmem[0], 16'h0FF0);
        check("g_load_done", done, 1);

        // illegal counts
        base = wr_cnt;
        send_list({8'hA5, 8'h00});
        idle(2);
        check("n0_err", error, 1);
        check("n0_hold", cpu_hold, 1);
        check("n0_done", done, 0);
        send_list({8'hA5});
        idle(1);
        check("hdr_clears_err", error, 0);
        send_list({8'h41});
        idle(1);
        check("n65_err", error, 1);
        send_list({8'h01, 8'h02, 8'h03, 8'h04, 8'h05});
        idle(2);
        check("n_cnt", wr_cnt - base, 0);

        // stop bit forced low mid-data
        base = wr_cnt;
        send_list({8'hA5, 8'h03, 8'h11, 8'h22});
        send_raw(8'h33, 1'b0);
        idle(2);
        send_list({8'h44, 8'h55, 8'h66, 8'h77, 8'h88});
        idle(2);
        check("f_cnt", wr_cnt - base, 1);
        check("f_w0", tmem[0], 16'h1122);
        check("f_err", error, 1);
        check("f_done", done, 0);
        check("f_hold", cpu_hold, 1);

        // full frame interrupted by reset after word 30
        base = wr_cnt;
        send_full(30);
        idle(2);
        check("r_cnt", wr_cnt - base, 30);
        check("r_addr", mem_addr, 29);
        check("r_wdata", mem_wdata, {8'd29, ~8'd29});
        check("r_hold", cpu_hold, 1);
        reset = 1'b1;
        #1;
        check("r_rst_hold", cpu_hold, 1);
        check("r_rst_addr", mem_addr, 0);
        check("r_rst_wdata", mem_wdata, 0);
        check("r_rst_we", mem_we, 0);
        check("r_rst_done", done, 0);
        check("r_rst_err", error, 0);
        @(negedge clock);
        reset = 1'b0;
        base = wr_cnt;
        for (int i = 30; i < 64; i++) send_list({8'(i), ~8'(i)});
        idle(2);
        check("r_no_wr", wr_cnt - base, 0);
        check("r_hold_after", cpu_hold, 1);

        // retransmit the full frame
        for (int i = 0; i < 64; i++) tmem[i] = 16'h0000;
        base = wr_cnt;
        send_full(64);
`ifdef LOADER_CHECKSUM_EN
        send_list({8'h00});
`endif
        idle(2);
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            iv = 8'(i);
            if (tmem[i] !== {iv, ~iv}) bad++;
        end
        check("full_cnt", wr_cnt - base, 64);
        check("full_bad_words", bad, 0);
        check("full_w63", tmem[63], 16'h3FC0);
        check("full_done", done, 1);
        check("full_hold", cpu_hold, 0);
        check("full_err", error, 0);
        check("we_width", we_long, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
